// File: rtl/consmax_row_normalizer.sv
// Softmax row normalizer: buffers one row of exponents and their sum, forms
// floor(2^RECIP_BIT / sum) with a serial divider, then streams saturated probabilities.

module consmax_row_normalizer #(
    parameter int ROW_LEN   = 256,
    parameter int DATA_BIT  = 8,
    parameter int OUT_BIT   = 8,
    parameter int RECIP_BIT = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_BIT-1:0] idata,
    input  logic                idata_valid,
    input  logic                idata_last,
    output logic                in_ready,
    output logic [OUT_BIT-1:0]  odata,
    output logic                odata_valid,
    output logic                odata_last,
    input  logic                out_ready
);

    localparam int IDX_BIT  = $clog2(ROW_LEN);
    localparam int SUM_BIT  = DATA_BIT + IDX_BIT + 1;
    localparam int LEN_BIT  = IDX_BIT + 1;
    localparam int Q_BIT    = RECIP_BIT + 1;
    localparam int REM_BIT  = SUM_BIT + 1;
    localparam int PROD_BIT = DATA_BIT + Q_BIT;
    localparam int DCNT_BIT = $clog2(RECIP_BIT + 1);
    localparam int SHIFT    = RECIP_BIT - OUT_BIT;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam logic [IDX_BIT-1:0]  CNT_LAST  = IDX_BIT'(ROW_LEN - 1);
    localparam logic [IDX_BIT-1:0]  CNT_ONE   = IDX_BIT'(1);
    localparam logic [IDX_BIT-1:0]  CNT_ZERO  = {IDX_BIT{1'b0}};
    localparam logic [LEN_BIT-1:0]  LEN_ONE   = LEN_BIT'(1);
    localparam logic [LEN_BIT-1:0]  LEN_ZERO  = {LEN_BIT{1'b0}};
    localparam logic [SUM_BIT-1:0]  SUM_ZERO  = {SUM_BIT{1'b0}};
    localparam logic [REM_BIT-1:0]  REM_ZERO  = {REM_BIT{1'b0}};
    localparam logic [Q_BIT-1:0]    Q_ZERO    = {Q_BIT{1'b0}};
    localparam logic [DCNT_BIT-1:0] DCNT_TOP  = DCNT_BIT'(RECIP_BIT);
    localparam logic [DCNT_BIT-1:0] DCNT_ONE  = DCNT_BIT'(1);
    localparam logic [DCNT_BIT-1:0] DCNT_ZERO = {DCNT_BIT{1'b0}};
    localparam logic [OUT_BIT-1:0]  OUT_MAX   = {OUT_BIT{1'b1}};
    localparam logic [OUT_BIT-1:0]  OUT_ZERO  = {OUT_BIT{1'b0}};
    localparam logic [PROD_BIT-1:0] PROD_MAX  = PROD_BIT'(OUT_MAX);

    logic [DATA_BIT-1:0] row_buf [ROW_LEN];

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [IDX_BIT-1:0]  cnt_r;
    logic [SUM_BIT-1:0]  sum_r;
    logic [LEN_BIT-1:0]  len_r;
    logic [REM_BIT-1:0]  rem_r;
    logic [Q_BIT-1:0]    quot_r;
    logic [DCNT_BIT-1:0] div_cnt_r;
    logic [LEN_BIT-1:0]  rd_idx_r;
    logic                in_ready_r;

    logic                s1_valid_r;
    logic                s1_last_r;
    logic [DATA_BIT-1:0] s1_data_r;
    logic [OUT_BIT-1:0]  odata_r;
    logic                odata_valid_r;
    logic                odata_last_r;

    logic                in_fire_s;
    logic                close_s;
    logic [SUM_BIT-1:0]  sum_add_s;
    logic [REM_BIT-1:0]  rem_shift_s;
    logic [REM_BIT-1:0]  rem_dif_s;
    logic                rem_ge_s;
    logic                out_adv_s;
    logic                s1_load_s;
    logic                rd_issue_s;
    logic                drain_done_s;
    logic [PROD_BIT-1:0] prod_s;
    logic [PROD_BIT-1:0] scaled_s;
    logic [OUT_BIT-1:0]  sat_s;

    assign in_ready    = in_ready_r;
    assign odata       = odata_r;
    assign odata_valid = odata_valid_r;
    assign odata_last  = odata_last_r;

    // Handshake, accumulation, divider step and drain pipeline control terms.
    always_comb begin
        in_fire_s    = idata_valid & in_ready_r;
        sum_add_s    = sum_r + SUM_BIT'(idata);
        close_s      = in_fire_s & (idata_last | (cnt_r == CNT_LAST));
        // Dividend 2^RECIP_BIT: a single one in the first step, zeros afterwards.
        rem_shift_s  = (rem_r << 1) | REM_BIT'(div_cnt_r == DCNT_TOP);
        rem_ge_s     = (rem_shift_s >= REM_BIT'(sum_r));
        rem_dif_s    = rem_shift_s - REM_BIT'(sum_r);
        out_adv_s    = ~odata_valid_r | out_ready;
        s1_load_s    = ~s1_valid_r | out_adv_s;
        rd_issue_s   = (state_r == ST_DRAIN) & (rd_idx_r < len_r) & s1_load_s;
        drain_done_s = odata_valid_r & out_ready & odata_last_r;
        prod_s       = PROD_BIT'(s1_data_r) * PROD_BIT'(quot_r);
        scaled_s     = prod_s >> SHIFT;
        if (scaled_s > PROD_MAX) begin
            sat_s = OUT_MAX;
        end else begin
            sat_s = scaled_s[OUT_BIT-1:0];
        end
    end

    // Next-state selection; a zero-sum row skips the divider entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (close_s) begin
                    state_nxt_s = (sum_add_s == SUM_ZERO) ? ST_DRAIN : ST_DIVIDE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DIVIDE: begin
                if (div_cnt_r == DCNT_ZERO) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_DIVIDE;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_FILL;
        endcase
    end

    // Row bookkeeping, serial restoring divider and drain read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FILL;
            cnt_r      <= CNT_ZERO;
            sum_r      <= SUM_ZERO;
            len_r      <= LEN_ZERO;
            rem_r      <= REM_ZERO;
            quot_r     <= Q_ZERO;
            div_cnt_r  <= DCNT_ZERO;
            rd_idx_r   <= LEN_ZERO;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_FILL);
            case (state_r)
                ST_FILL: begin
                    if (in_fire_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        sum_r <= sum_add_s;
                    end
                    if (close_s) begin
                        len_r     <= LEN_BIT'(cnt_r) + LEN_ONE;
                        rem_r     <= REM_ZERO;
                        quot_r    <= Q_ZERO;
                        div_cnt_r <= DCNT_TOP;
                        rd_idx_r  <= LEN_ZERO;
                    end
                end
                ST_DIVIDE: begin
                    rem_r     <= rem_ge_s ? rem_dif_s : rem_shift_s;
                    quot_r    <= (quot_r << 1) | Q_BIT'(rem_ge_s);
                    div_cnt_r <= div_cnt_r - DCNT_ONE;
                end
                ST_DRAIN: begin
                    if (rd_issue_s) begin
                        rd_idx_r <= rd_idx_r + LEN_ONE;
                    end
                    if (drain_done_s) begin
                        cnt_r <= CNT_ZERO;
                        sum_r <= SUM_ZERO;
                    end
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                    sum_r <= SUM_ZERO;
                end
            endcase
        end
    end

    // Row buffer write port and registered read port (first drain stage).
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            row_buf[cnt_r] <= idata;
        end
        if (rd_issue_s) begin
            s1_data_r <= row_buf[rd_idx_r[IDX_BIT-1:0]];
        end
    end

    // Read-stage valid/last flags; they only advance when the output stage can take them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= rd_issue_s;
            end
            if (rd_issue_s) begin
                s1_last_r <= (rd_idx_r == (len_r - LEN_ONE));
            end
        end
    end

    // Output stage: multiply by the reciprocal, saturate, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odata_r       <= OUT_ZERO;
            odata_valid_r <= 1'b0;
            odata_last_r  <= 1'b0;
        end else if (out_adv_s) begin
            odata_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                odata_r      <= sat_s;
                odata_last_r <= s1_last_r;
            end else begin
                odata_last_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_consmax_row_normalizer.sv
// Self-checking bench for consmax_row_normalizer: directed rows from the test plan plus
// randomized rows, all checked against a queue-based reference model of the row math.

module tb_consmax_row_normalizer;

    localparam int ROW_LEN   = 256;
    localparam int RECIP_BIT = 24;
    localparam int OUT_BIT   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] idata;
    logic       idata_valid;
    logic       idata_last;
    logic       in_ready;
    logic [7:0] odata;
    logic       odata_valid;
    logic       odata_last;
    logic       out_ready;

    consmax_row_normalizer #(
        .ROW_LEN  (ROW_LEN),
        .DATA_BIT (8),
        .OUT_BIT  (OUT_BIT),
        .RECIP_BIT(RECIP_BIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .idata      (idata),
        .idata_valid(idata_valid),
        .idata_last (idata_last),
        .in_ready   (in_ready),
        .odata      (odata),
        .odata_valid(odata_valid),
        .odata_last (odata_last),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        bit l;
    } exp_t;

    int   n_pass  = 0;
    int   n_total = 0;
    int   mrow[$];
    exp_t exp_q[$];
    int   got_d[$];
    bit   got_l[$];
    int   row_v[300];
    int   last_sum;
    int   close_cyc;
    int   last_beat_cyc;
    int   first_valid_cyc;
    int   last_xfer_cyc;
    int   ready_mode = 0;
    int   pidx = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint m_recip(input longint s);
        if (s == 0) return 0;
        return (64'd1 << RECIP_BIT) / s;
    endfunction

    function automatic int m_out(input longint v, input longint r);
        longint q;
        q = (v * r) >> (RECIP_BIT - OUT_BIT);
        return (q > 255) ? 255 : int'(q);
    endfunction

    // Reference model: the closed row's sum, reciprocal and expected output stream.
    task automatic close_row();
        longint s = 0;
        longint r;
        foreach (mrow[i]) s += mrow[i];
        r = m_recip(s);
        last_sum = int'(s);
        foreach (mrow[i]) exp_q.push_back('{m_out(mrow[i], r), i == mrow.size() - 1});
        mrow.delete();
    endtask

    task automatic send_beat(input int v, input bit l, output bit ok);
        int g = 0;
        idata = 8'(v); idata_valid = 1'b1; idata_last = l;
        while (!in_ready && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            idata_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        last_beat_cyc = cyc;
        @(posedge clk);
        mrow.push_back(v);
        if (l || mrow.size() == ROW_LEN) begin
            close_row();
            close_cyc = last_beat_cyc;
        end
        @(negedge clk);
        idata_valid = 1'b0; idata_last = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_first_valid(output int lat);
        int g = 0;
        while (!odata_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        first_valid_cyc = cyc;
        lat = odata_valid ? (cyc - close_cyc) : -1;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_row(input string name, input int n, input bit use_last);
        bit ok;
        int lat;
        for (int i = 0; i < n; i++) begin
            send_beat(row_v[i], use_last && (i == n - 1), ok);
            if (!ok) return;
        end
        wait_first_valid(lat);
        check({name, "_latency"}, lat, (last_sum == 0) ? 3 : RECIP_BIT + 4);
        wait_drain(name);
    endtask

    task automatic check_got(input string name, input int v, input int n);
        check({name, "_count"}, got_d.size(), n);
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            check({name, "_data"}, got_d[i], v);
            check({name, "_last"}, got_l[i], (i == n - 1) ? 1 : 0);
        end
        got_d.delete();
        got_l.delete();
    endtask

    // Downstream ready generator, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    out_ready = ((pidx % 4) == 0) || ((pidx % 4) == 3);
                    pidx++;
                end
                3: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Compare process: output stream, stall stability and input-side gating.
    initial begin
        bit         pv = 1'b0;
        bit         pr = 1'b0;
        bit         pl = 1'b0;
        bit         lx = 1'b0;
        logic [7:0] pd = 8'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                lx = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", odata_valid, 1);
                    check("hold_data", odata, pd);
                    check("hold_last", odata_last, pl);
                end
                if (lx) check("in_ready_reassert", in_ready, 1);
                if (exp_q.size() > 0) check("in_ready_low", in_ready, 0);
                lx = 1'b0;
                if (odata_valid && out_ready) begin
                    check("output_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("odata", odata, e.d);
                        check("odata_last", odata_last, e.l);
                    end
                    got_d.push_back(int'(odata));
                    got_l.push_back(odata_last);
                    if (odata_last) last_xfer_cyc = cyc;
                    lx = odata_last;
                end
                pv = odata_valid; pr = out_ready; pd = odata; pl = odata_last;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        rst_n = 1'b0; idata = 8'd0; idata_valid = 1'b0; idata_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_odata", odata, 0);
        check("reset_odata_valid", odata_valid, 0);
        check("reset_odata_last", odata_last, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // Uniform row, full-throughput drain.
        for (int i = 0; i < 4; i++) row_v[i] = 1;
        run_row("uniform", 4, 1'b1);
        check("uniform_sum", last_sum, 4);
        check("uniform_throughput", last_xfer_cyc - first_valid_cyc, 3);
        check_got("uniform", 64, 4);

        row_v[0] = 200;
        run_row("single200", 1, 1'b1);
        check_got("single200", 255, 1);

        row_v[0] = 1;
        run_row("saturate", 1, 1'b1);
        check_got("saturate", 255, 1);

        for (int i = 0; i < 3; i++) row_v[i] = 0;
        run_row("zero", 3, 1'b1);
        check_got("zero", 0, 3);

        // Forced close at ROW_LEN with a 1,0,0,1 ready pattern; the next beat must wait.
        ready_mode = 2;
        for (int i = 0; i < ROW_LEN; i++) begin
            send_beat(2, 1'b0, ok);
        end
        check("forced_sum", last_sum, 512);
        send_beat(2, 1'b0, ok);
        check("forced_refill_gap", last_beat_cyc - last_xfer_cyc, 1);
        check_got("forced", 1, ROW_LEN);
        send_beat(2, 1'b0, ok);
        send_beat(2, 1'b1, ok);
        wait_drain("forced_tail");
        check_got("forced_tail", 85, 3);

        // Reset during DIVIDE.
        ready_mode = 0;
        row_v[0] = 5; row_v[1] = 6; row_v[2] = 7;
        for (int i = 0; i < 3; i++) send_beat(row_v[i], i == 2, ok);
        while (cyc < close_cyc + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_div_in_ready", in_ready, 0);
        check("rst_div_odata_valid", odata_valid, 0);
        exp_q.delete(); mrow.delete(); got_d.delete(); got_l.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_div_in_ready_after", in_ready, 1);

        // Reset while an output is stalled in DRAIN.
        ready_mode = 3;
        row_v[0] = 10; row_v[1] = 20; row_v[2] = 30; row_v[3] = 40;
        for (int i = 0; i < 4; i++) send_beat(row_v[i], i == 3, ok);
        begin
            int lat;
            wait_first_valid(lat);
            check("stall_latency", lat, RECIP_BIT + 4);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_drain_odata_valid", odata_valid, 0);
        check("rst_drain_odata", odata, 0);
        check("rst_drain_odata_last", odata_last, 0);
        exp_q.delete(); mrow.delete(); got_d.delete(); got_l.delete();
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_drain_in_ready_after", in_ready, 1);
        row_v[0] = 3; row_v[1] = 1;
        run_row("after_reset", 2, 1'b1);
        check("after_reset_count", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("after_reset_d0", got_d[0], 192);
            check("after_reset_d1", got_d[1], 64);
        end
        got_d.delete(); got_l.delete();

        // Randomized rows under random backpressure.
        ready_mode = 1;
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                if (r % 4 == 3) row_v[i] = $urandom_range(0, 3);
                else if (r % 4 == 2) row_v[i] = 0;
                else row_v[i] = $urandom_range(0, 255);
            end
            run_row("random", n, 1'b1);
            got_d.delete(); got_l.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
